bitcoin_nonce_scan: RTL
=======================

// Module: bitcoin_nonce_scan
// PURPOSE
//  Post-processing reader for the bitcoin hash engine's output: after the engine has written its
//  NUM_NONCES final H0 words to result_addr..result_addr+NUM_NONCES-1, this block reads them back
//  over the same shared synchronous memory port, compares each against a difficulty target, and
//  reports the winning nonce. The verdict is written to memory as one status word at status_addr.
// PARAMETERS
//  NUM_NONCES  16   number of consecutive hash words scanned (index = nonce)
//  ADDR_W      16   memory address width
//  DATA_W      32   memory word / hash width
// PORTS
//  clk             in   1       clock; also forwarded as mem_clk
//  reset_n         in   1       asynchronous active-low reset
//  start           in   1       begin scan; sampled only in IDLE
//  result_addr     in   ADDR_W  base address of hash words; sampled with start
//  status_addr     in   ADDR_W  address of status word; sampled with start
//  target          in   DATA_W  difficulty threshold (unsigned); sampled with start
//  done            out  1       1 while idle, 0 while scanning
//  found           out  1       some hash < target
//  nonce           out  NW      winning index, NW = $clog2(NUM_NONCES)
//  min_hash        out  DATA_W  hash of reported nonce (see CONFIGURATION)
//  mem_clk         out  1       = clk
//  mem_we          out  1       memory write enable
//  mem_addr        out  ADDR_W  memory address (registered)
//  mem_write_data  out  DATA_W  memory write data (registered)
//  mem_read_data   in   DATA_W  memory read data
// BEHAVIOUR
//  Reset: done=0, found=0, nonce=0, min_hash='1, mem_we=0, mem_addr=0, mem_write_data=0, state=IDLE.
//  Memory timing: address registered at edge N is captured from mem_read_data at edge N+2;
//   one address is issued per cycle (pipelined, 2 reads in flight).
//  FSM states: IDLE, ISSUE, DRAIN, WRITE, FIN.
//  IDLE: done<=1, mem_we<=0. On start: latch inputs, done<=0, found<=0, min_hash<='1,
//   mem_addr<=result_addr, issue counter ic<=1, state ISSUE.
//  ISSUE: mem_addr<=result_addr+ic, ic++; after index NUM_NONCES-1 is issued -> DRAIN.
//  Capture: a 2-deep valid pipe tracks issued reads; each valid capture at index cc compares
//   mem_read_data < target (unsigned, full DATA_W); cc++.
//  DRAIN: wait until capture of index NUM_NONCES-1 -> WRITE.
//  WRITE: mem_we<=1, mem_addr<=status_addr, mem_write_data<={found,0...,nonce} (found in MSB,
//   nonce in low NW bits, zeros between) using the verdict including the final capture -> FIN.
//  FIN: mem_we<=0, state IDLE (done rises the following edge).
//  Latency, NUM_NONCES=16: start edge 0; captures at edges 2..17; mem_we high after edge 18; done=1
//   after edge 20.
//  Boundaries: hash == target is NOT a hit; target=0 -> found=0, nonce=0; start while busy ignored;
//   reset mid-scan aborts with no status write and all outputs to reset values; mem_read_data is
//   ignored outside capture slots.
// CONFIGURATION
//  BEST_TRACK_EN defined: nonce = index of minimum hash over all NUM_NONCES (tie -> lower index);
//   min_hash = that minimum; found = (minimum < target).
//  BEST_TRACK_EN undefined: nonce = first (lowest) index with hash < target; min_hash = its hash;
//   later hits ignored; no hit -> found=0, nonce=0, min_hash='1.
//  Port list and timing are identical in both builds.
// STRUCTURE
//  bitcoin_pkg: scan_state_t enum, status-word field positions (FOUND_BIT), HASH_ALL_ONES constant.
//  Sub-module nonce_select: per-capture compare/update of {found, nonce, min_hash}; the only place
//   the BEST_TRACK_EN variant is compiled.
// TESTING (memory model: synchronous RAM, 1-cycle registered read on mem_clk)
//  1. target=32'h0000_1000, hashes idx5=32'h0000_0800, idx9=32'h0000_0100, others 32'hFFFF_0000 ->
//     first-hit: nonce=5, min_hash=32'h0000_0800; BEST_TRACK_EN: nonce=9, min_hash=32'h0000_0100;
//     status word=32'h8000_0005 or 32'h8000_0009.
//  2. All hashes = target=32'h1234_5678 -> found=0, nonce=0, status word 32'h0000_0000.
//  3. Only idx15=32'h0 (last capture), target=1 -> found=1, nonce=15, status 32'h8000_000F at
//     status_addr.
//  4. Check timing from start edge 0: reads at result_addr+0..15 on consecutive cycles, single
//     mem_we pulse after edge 18, done=1 after edge 20; start pulse during scan ignored.
//  5. reset_n low at edge 8 -> no write ever issued, outputs at reset values; rerun scan is correct.
//  6. BEST_TRACK_EN tie: idx3=idx7=32'h10, target=32'h20 -> nonce=3, min_hash=32'h10.

Source files
------------

// File: rtl/bitcoin_pkg.sv
// bitcoin_pkg: shared types and constants for the nonce scanner.
//   scan_state_t  - scanner FSM states
//   FOUND_BIT     - bit position of the found flag in the status word
//   HASH_ALL_ONES - "no hash yet" value for min_hash
package bitcoin_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    WRITE,
    FIN
  } scan_state_t;

  localparam int FOUND_BIT = 31;
  localparam logic [31:0] HASH_ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/bitcoin_nonce_scan_if.sv
// bitcoin_nonce_scan_if: shared synchronous memory port used by the scanner.
//   mem_we         - write enable (master -> memory)
//   mem_addr       - address, registered by the master
//   mem_write_data - write data, registered by the master
//   mem_read_data  - read data (memory -> master)
// Modports: master (scanner side), slave (memory side).
interface bitcoin_nonce_scan_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) ();

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_write_data,
    input  mem_read_data
  );

  modport slave (
    input  mem_we,
    input  mem_addr,
    input  mem_write_data,
    output mem_read_data
  );

endinterface

// File: rtl/nonce_select.sv
// nonce_select: per-capture compare/update of the {found, nonce, min_hash} verdict.
// Optional feature macro: BEST_TRACK_EN
//   defined   - track the minimum hash over all captures (ties keep the lower index)
//   undefined - keep the first capture whose hash is below target
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   clear        - start of a new scan, returns the verdict to "nothing found"
//   cap_en       - a read result is being captured this cycle
//   cap_idx      - nonce index of the captured word
//   cap_data     - captured hash word
//   target       - difficulty threshold (unsigned)
//   found, nonce, min_hash - current verdict
module nonce_select
  import bitcoin_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NW     = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              cap_en,
  input  logic [NW-1:0]     cap_idx,
  input  logic [DATA_W-1:0] cap_data,
  input  logic [DATA_W-1:0] target,
  output logic              found,
  output logic [NW-1:0]     nonce,
  output logic [DATA_W-1:0] min_hash
);

  logic hit;

  // Strict compare: a hash equal to the target does not qualify.
  assign hit = cap_data < target;

`ifdef BEST_TRACK_EN
  // Strict less-than keeps the earlier index on ties; found follows the
  // running minimum, which only changes when a smaller hash arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      found    <= 1'b0;
      nonce    <= '0;
      min_hash <= DATA_W'(HASH_ALL_ONES);
    end else if (clear) begin
      found    <= 1'b0;
      nonce    <= '0;
      min_hash <= DATA_W'(HASH_ALL_ONES);
    end else if (cap_en && (cap_data < min_hash)) begin
      found    <= hit;
      nonce    <= cap_idx;
      min_hash <= cap_data;
    end
  end
`else
  // Once a hit is latched, later hits are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      found    <= 1'b0;
      nonce    <= '0;
      min_hash <= DATA_W'(HASH_ALL_ONES);
    end else if (clear) begin
      found    <= 1'b0;
      nonce    <= '0;
      min_hash <= DATA_W'(HASH_ALL_ONES);
    end else if (cap_en && !found && hit) begin
      found    <= 1'b1;
      nonce    <= cap_idx;
      min_hash <= cap_data;
    end
  end
`endif

endmodule

// File: rtl/bitcoin_nonce_scan.sv
// bitcoin_nonce_scan: reads back NUM_NONCES hash words from result_addr onward,
// compares each with target and writes a status word {found, 0.., nonce}
// to status_addr.
// Optional feature macro: BEST_TRACK_EN (see nonce_select).
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   start         - begin scan (sampled only while idle, with the three inputs below)
//   result_addr   - base address of the hash words
//   status_addr   - address of the status word
//   target        - difficulty threshold (unsigned)
//   done          - 1 while idle, 0 while scanning
//   found, nonce, min_hash - verdict of the latest scan
//   mem_clk       - memory clock (= clk)
//   mem           - memory port (master modport): we/addr/write_data/read_data
// Memory timing: address registered at edge N, read data sampled at edge N+2.
module bitcoin_nonce_scan
  import bitcoin_pkg::*;
#(
  parameter  int NUM_NONCES = 16,
  parameter  int ADDR_W     = 16,
  parameter  int DATA_W     = 32,
  localparam int NW         = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           result_addr,
  input  logic [ADDR_W-1:0]           status_addr,
  input  logic [DATA_W-1:0]           target,
  output logic                        done,
  output logic                        found,
  output logic [NW-1:0]               nonce,
  output logic [DATA_W-1:0]           min_hash,
  output logic                        mem_clk,
  bitcoin_nonce_scan_if.master        mem
);

  localparam logic [NW-1:0] LAST_IDX = NW'(NUM_NONCES - 1);

  scan_state_t       state, next_state;
  logic [NW-1:0]     ic, cc;
  logic              issue_v, pipe_v;
  logic [ADDR_W-1:0] result_q, status_q;
  logic [DATA_W-1:0] target_q;
  logic              start_ok;

  logic              done_d, we_d, issue_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d, status_word;

  assign mem_clk  = clk;
  assign start_ok = (state == IDLE) && start;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic. DRAIN leaves on the capture of the last index.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (NUM_NONCES == 1) ? DRAIN : ISSUE;
      ISSUE:   if (ic == LAST_IDX) next_state = DRAIN;
      DRAIN:   if (pipe_v && (cc == LAST_IDX)) next_state = WRITE;
      WRITE:   next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Status word: found flag in the MSB, nonce in the low bits.
  always_comb begin
    status_word              = '0;
    status_word[FOUND_BIT]   = found;
    status_word[NW-1:0]      = nonce;
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    done_d  = done;
    we_d    = 1'b0;
    issue_d = 1'b0;
    addr_d  = mem.mem_addr;
    wdata_d = mem.mem_write_data;
    case (state)
      IDLE: begin
        done_d = 1'b1;
        if (start) begin
          done_d  = 1'b0;
          addr_d  = result_addr;
          issue_d = 1'b1;
        end
      end
      ISSUE: begin
        addr_d  = result_q + ADDR_W'(ic);
        issue_d = 1'b1;
      end
      WRITE: begin
        we_d    = 1'b1;
        addr_d  = status_q;
        wdata_d = status_word;
      end
      default: ;
    endcase
  end

  // Registered outputs plus the 2-deep valid pipe that marks capture slots.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done               <= 1'b0;
      mem.mem_we         <= 1'b0;
      mem.mem_addr       <= '0;
      mem.mem_write_data <= '0;
      issue_v            <= 1'b0;
      pipe_v             <= 1'b0;
    end else begin
      done               <= done_d;
      mem.mem_we         <= we_d;
      mem.mem_addr       <= addr_d;
      mem.mem_write_data <= wdata_d;
      issue_v            <= issue_d;
      pipe_v             <= issue_v;
    end
  end

  // Scan inputs are latched at start; ic counts issued reads, cc captured ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= '0;
      status_q <= '0;
      target_q <= '0;
      ic       <= '0;
      cc       <= '0;
    end else begin
      if (start_ok) begin
        result_q <= result_addr;
        status_q <= status_addr;
        target_q <= target;
        ic       <= NW'(1);
      end else if (state == ISSUE) begin
        ic <= ic + 1'b1;
      end
      if (start_ok)    cc <= '0;
      else if (pipe_v) cc <= cc + 1'b1;
    end
  end

  nonce_select #(
    .DATA_W (DATA_W),
    .NW     (NW)
  ) u_nonce_select (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (start_ok),
    .cap_en   (pipe_v),
    .cap_idx  (cc),
    .cap_data (mem.mem_read_data),
    .target   (target_q),
    .found    (found),
    .nonce    (nonce),
    .min_hash (min_hash)
  );

endmodule
